// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and default memory depth.
package lsu_pkg;

  localparam int unsigned DEFAULT_DEPTH = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends a load lane from a memory word and merges
// store data into an old word, little-endian.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  input  lsu_size_e   size,
  input  logic [1:0]  lane,
  input  logic        zero_ext,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_word;
  logic [31:0] half_word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  always_comb begin
    byte_sh   = {lane, 3'b000};
    half_sh   = {lane[1], 4'b0000};
    byte_word = rd_word >> byte_sh;
    half_word = rd_word >> half_sh;
    byte_v    = byte_word[7:0];
    half_v    = half_word[15:0];
    byte_mask = 32'h0000_00ff << byte_sh;
    half_mask = 32'h0000_ffff << half_sh;
  end

  always_comb begin
    load_data = 32'h0;
    case (size)
      SZ_BYTE: load_data = zero_ext ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: load_data = zero_ext ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      SZ_WORD: load_data = rd_word;
      SZ_RSVD: load_data = 32'h0;
    endcase
  end

  // Non-target bytes of the old word pass through untouched.
  always_comb begin
    merged_word = rd_word;
    case (size)
      SZ_BYTE: merged_word = (rd_word & ~byte_mask) | (({24'h0, wr_data[7:0]} << byte_sh) & byte_mask);
      SZ_HALF: merged_word = (rd_word & ~half_mask) | (({16'h0, wr_data[15:0]} << half_sh) & half_mask);
      SZ_WORD: merged_word = wr_data;
      SZ_RSVD: merged_word = rd_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-organised data memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_FAULT_EN to fault misaligned accesses instead of aligning them down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] DAddr,
  output logic [31:0] DataIn,
  output logic        DataMemRW,
  input  logic [31:0] DataOut
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  lsu_state_e  state_q;
  logic        wr_q;
  lsu_size_e   size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  lsu_size_e   size_in;
  logic [1:0]  lane_in;
  logic [31:0] word_idx;
  logic        accept;
  logic        size_rsvd;
  logic        misalign;
  logic        out_of_range;
  logic        fault;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign size_in   = lsu_size_e'(req_size);
  assign word_idx  = 32'(req_addr[AW+1:2]);

  always_comb begin
    size_rsvd    = (size_in == SZ_RSVD);
    out_of_range = (req_addr >= ADDR_LIMIT);
`ifdef LSU_MISALIGN_FAULT_EN
    misalign = ((size_in == SZ_HALF) && req_addr[0]) ||
               ((size_in == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    fault = size_rsvd | misalign | out_of_range;
  end

  // Lane offset as used by the access; without the fault option, bits below the size drop.
  always_comb begin
    lane_in = req_addr[1:0];
`ifndef LSU_MISALIGN_FAULT_EN
    if (size_in == SZ_HALF) begin
      lane_in[0] = 1'b0;
    end else if (size_in == SZ_WORD) begin
      lane_in = 2'b00;
    end
`endif
  end

  lsu_lane_align u_lane_align (
    .rd_word     (DataOut),
    .wr_data     (wdata_q),
    .size        (size_q),
    .lane        (lane_q),
    .zero_ext    (uns_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_fault <= 1'b0;
      DAddr      <= 32'h0;
      DataIn     <= 32'h0;
      DataMemRW  <= 1'b0;
    end else begin
      // Single-cycle pulses by default; DAddr/DataIn hold unless reloaded below.
      resp_valid <= 1'b0;
      DataMemRW  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            wr_q    <= req_write;
            size_q  <= size_in;
            uns_q   <= req_unsigned;
            lane_q  <= lane_in;
            wdata_q <= req_wdata;
            if (fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= 32'h0;
              state_q    <= RESP;
            end else begin
              DAddr <= word_idx;
              if (req_write && (size_in == SZ_WORD)) begin
                DataIn    <= req_wdata;
                DataMemRW <= 1'b1;
                state_q   <= WRITE;
              end else begin
                state_q <= READ;
              end
            end
          end
        end
        READ: begin
          if (wr_q) begin
            DataIn    <= merged_word;
            DataMemRW <= 1'b1;
            state_q   <= WRITE;
          end else begin
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= load_data;
            state_q    <= RESP;
          end
        end
        WRITE: begin
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= 32'h0;
          state_q    <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a small word memory model.
module tb_load_store_unit;

  logic        CLK;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic        DataMemRW;
  logic [31:0] DataOut;

  load_store_unit dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .DAddr        (DAddr),
    .DataIn       (DataIn),
    .DataMemRW    (DataMemRW),
    .DataOut      (DataOut)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory model: combinational read, write on the rising edge; pokes preload words.
  logic [31:0] mem [0:31];
  logic        poke_en;
  logic [4:0]  poke_idx;
  logic [31:0] poke_val;

  assign DataOut = mem[DAddr[4:0]];

  always @(posedge CLK) begin
    if (DataMemRW) mem[DAddr[4:0]] <= DataIn;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  int cyc = 0;
  int wr_cycles = 0;
  int long_pulse = 0;
  int unstable = 0;
  logic prev_rw = 1'b0;
  logic [31:0] din_snap;
  logic [31:0] addr_snap;

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (DataMemRW && ((DataIn !== din_snap) || (DAddr !== addr_snap))) unstable = unstable + 1;
  end

  always @(negedge CLK) begin
    if (DataMemRW) begin
      wr_cycles = wr_cycles + 1;
      if (prev_rw) long_pulse = long_pulse + 1;
      din_snap  = DataIn;
      addr_snap = DAddr;
    end
    prev_rw = DataMemRW;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pops the oldest expectation.
  always @(negedge CLK) begin
    if (resp_valid === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL unexpected_resp: got rdata 0x%08h fault %0b with nothing expected",
                 resp_rdata, resp_fault);
      end else begin
        e = sb.pop_front();
        check({e.name, ".rdata"}, resp_rdata, e.rdata);
        check({e.name, ".fault"}, 32'(resp_fault), 32'(e.fault));
        check({e.name, ".latency"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge CLK);
    poke_en  = 1'b1;
    poke_idx = 5'(idx);
    poke_val = val;
    @(negedge CLK);
    poke_en  = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_fault,
                       input int lat, input int exp_writes, input string name);
    int w0;
    exp_t e;
    @(negedge CLK);
    check({name, ".ready"}, 32'(req_ready), 32'd1);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    e.rdata = exp_rdata;
    e.fault = exp_fault;
    e.acc   = cyc;
    e.lat   = lat;
    e.name  = name;
    sb.push_back(e);
    w0 = wr_cycles;
    @(negedge CLK);
    req_valid = 1'b0;
    req_addr  = 32'hffff_ffff;
    req_wdata = 32'h0bad_0bad;
    for (int i = 0; i < 20 && !(req_ready && sb.size() == 0); i++) @(negedge CLK);
    if (sb.size() != 0) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL %s.timeout: got no response, expected one within 20 cycles", name);
      sb.delete();
    end
    check({name, ".writes"}, 32'(wr_cycles - w0), 32'(exp_writes));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected one before 100000 time units");
    $fatal(1);
  end

  initial begin
    Reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    poke_en      = 1'b0;
    poke_idx     = 5'd0;
    poke_val     = 32'h0;
    din_snap     = 32'h0;
    addr_snap    = 32'h0;
    #1;
    check("rst.req_ready",  32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'h0);
    check("rst.resp_fault", 32'(resp_fault), 32'd0);
    check("rst.DAddr",      DAddr, 32'h0);
    check("rst.DataIn",     DataIn, 32'h0);
    check("rst.DataMemRW",  32'(DataMemRW), 32'd0);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;

    poke(0, 32'h0123_4567);
    poke(1, 32'hcafe_f00d);
    poke(31, 32'h9abc_def0);

    // Word store then word load.
    issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hdead_beef, 32'h0, 1'b0, 2, 1, "st_w08");
    check("mem2_after_store", mem[2], 32'hdead_beef);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'hdead_beef, 1'b0, 2, 0, "ld_w08");
    check("daddr_after_load", DAddr, 32'd2);

    // Byte read-modify-write.
    poke(3, 32'h1122_3344);
    issue(1'b1, 2'b00, 1'b0, 32'h0d, 32'hffff_ffaa, 32'h0, 1'b0, 3, 1, "st_b0d");
    check("mem3_after_byte_store", mem[3], 32'h1122_aa44);

    // Lane extraction and extension.
    poke(3, 32'h8000_ff7f);
    issue(1'b0, 2'b00, 1'b0, 32'h0c, 32'h0, 32'h0000_007f, 1'b0, 2, 0, "ld_bs0c");
    issue(1'b0, 2'b00, 1'b0, 32'h0d, 32'h0, 32'hffff_ffff, 1'b0, 2, 0, "ld_bs0d");
    issue(1'b0, 2'b00, 1'b1, 32'h0d, 32'h0, 32'h0000_00ff, 1'b0, 2, 0, "ld_bu0d");
    issue(1'b0, 2'b01, 1'b1, 32'h0e, 32'h0, 32'h0000_8000, 1'b0, 2, 0, "ld_hu0e");
    issue(1'b0, 2'b01, 1'b0, 32'h0e, 32'h0, 32'hffff_8000, 1'b0, 2, 0, "ld_hs0e");
    issue(1'b0, 2'b00, 1'b1, 32'h7f, 32'h0, 32'h0000_009a, 1'b0, 2, 0, "ld_bu7f");

    // Half read-modify-write on the upper lane.
    issue(1'b1, 2'b01, 1'b0, 32'h0e, 32'h1234_5a5a, 32'h0, 1'b0, 3, 1, "st_h0e");
    check("mem3_after_half_store", mem[3], 32'h5a5a_ff7f);

    // Misaligned accesses.
`ifdef LSU_MISALIGN_FAULT_EN
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0, "ld_w06");
    issue(1'b0, 2'b01, 1'b0, 32'h07, 32'h0, 32'h0, 1'b1, 1, 0, "ld_h07");
`else
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'hcafe_f00d, 1'b0, 2, 0, "ld_w06");
    issue(1'b0, 2'b01, 1'b0, 32'h07, 32'h0, 32'hffff_cafe, 1'b0, 2, 0, "ld_h07");
`endif

    // Range and reserved-size faults.
    issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h5555_aaaa, 32'h0, 1'b1, 1, 0, "st_w80");
    check("mem0_after_range_fault", mem[0], 32'h0123_4567);
    issue(1'b1, 2'b11, 1'b0, 32'h00, 32'h5555_aaaa, 32'h0, 1'b1, 1, 0, "st_rsvd");
    check("mem0_after_rsvd_fault", mem[0], 32'h0123_4567);
    issue(1'b0, 2'b00, 1'b0, 32'hffff_fffc, 32'h0, 32'h0, 1'b1, 1, 0, "ld_bhigh");

    // Reset during the write cycle of a byte store.
    poke(5, 32'h5555_5555);
    @(negedge CLK);
    req_write    = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h15;
    req_wdata    = 32'h0000_00cc;
    req_valid    = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    for (int i = 0; i < 6 && DataMemRW !== 1'b1; i++) @(negedge CLK);
    check("rmw_reached_write", 32'(DataMemRW), 32'd1);
    Reset = 1'b1;
    #1;
    check("midrst.DataMemRW",  32'(DataMemRW), 32'd0);
    check("midrst.req_ready",  32'(req_ready), 32'd1);
    check("midrst.resp_valid", 32'(resp_valid), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    repeat (4) @(negedge CLK);
    check("mem5_after_midrst", mem[5], 32'h5555_5555);
    check("post_midrst.ready", 32'(req_ready), 32'd1);

    check("write_pulse_over_one_cycle", 32'(long_pulse), 32'd0);
    check("write_data_unstable", 32'(unstable), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
